pc_stack: RTL

PC_STACK -- requirements
Module: pc_stack

---
 rtl/pc_stack.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/pc_stack.sv
`default_nettype none
// ============================================================================
// Module      : pc_stack
// Description : Program counter with a LIFO return-address stack.
//               One operation per cycle, priority ret > call > load > inc.
//               The PC and all flags are registered, so inputs never reach
//               outputs combinationally.
// Ports       : clk              - single clock, rising edge
//               rstn             - synchronous active-low reset
//               inc              - advance PC by one
//               load             - jump: PC <= load_addr
//               load_addr        - jump / call target
//               call             - push PC+1, then PC <= load_addr
//               ret              - pop top of stack into PC
//               cnt_val          - current PC (register output)
//               max_size_reached - sticky: inc requested while PC = MAX
//               stack_full       - occupancy = STACK_DEPTH
//               stack_empty      - occupancy = 0
//               stack_err        - sticky: call when full or ret when empty
// Revision    : 1.0 - initial release
// ============================================================================
module pc_stack #(
  parameter int                ADDR_W      = 5,
  parameter int                STACK_DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_VEC   = '0,
  parameter int                WRAP        = 0
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              inc,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic              call,
  input  logic              ret,
  output logic [ADDR_W-1:0] cnt_val,
  output logic              max_size_reached,
  output logic              stack_full,
  output logic              stack_empty,
  output logic              stack_err
);

  localparam int                OCC_W   = $clog2(STACK_DEPTH + 1);
  localparam logic [ADDR_W-1:0] C_PC_MAX = '1;
  localparam logic [OCC_W-1:0]  C_OCC_FULL = OCC_W'(STACK_DEPTH);

  // Architectural state
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [OCC_W-1:0]  occ_q, occ_d;
  logic              max_q, max_d;
  logic              err_q, err_d;
  logic [ADDR_W-1:0] entry_q [STACK_DEPTH];

  // Datapath helpers
  logic              w_push;
  logic [ADDR_W-1:0] w_ret_addr;
  logic [ADDR_W-1:0] w_top;
  logic              w_full;
  logic              w_empty;

  assign w_full     = (occ_q == C_OCC_FULL);
  assign w_empty    = (occ_q == '0);
  // Natural ADDR_W-bit rollover gives (PC+1) mod 2^ADDR_W.
  assign w_ret_addr = pc_q + ADDR_W'(1);

  // Top of stack is the entry just below the occupancy count.
  always_comb begin
    w_top = '0;
    for (int i = 0; i < STACK_DEPTH; i++) begin
      if (occ_q == OCC_W'(i + 1)) begin
        w_top = entry_q[i];
      end
    end
  end

  // Next-state selection in priority order; lower requests are dropped.
  always_comb begin
    pc_d   = pc_q;
    occ_d  = occ_q;
    max_d  = max_q;
    err_d  = err_q;
    w_push = 1'b0;
    if (ret) begin
      if (w_empty) begin
        err_d = 1'b1;
      end else begin
        pc_d  = w_top;
        occ_d = occ_q - OCC_W'(1);
      end
    end else if (call) begin
      if (w_full) begin
        err_d = 1'b1;
      end else begin
        w_push = 1'b1;
        pc_d   = load_addr;
        occ_d  = occ_q + OCC_W'(1);
      end
    end else if (load) begin
      pc_d = load_addr;
    end else if (inc) begin
      if (pc_q == C_PC_MAX) begin
        max_d = 1'b1;
        pc_d  = (WRAP != 0) ? '0 : pc_q;
      end else begin
        pc_d = pc_q + ADDR_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      pc_q  <= RESET_VEC;
      occ_q <= '0;
      max_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      occ_q <= occ_d;
      max_q <= max_d;
      err_q <= err_d;
    end
  end

  // Entry contents need no reset: ret on an empty stack never reads them.
  // A push lands in the slot indexed by the current occupancy.
  generate
    for (genvar e = 0; e < STACK_DEPTH; e++) begin : g_entry
      always_ff @(posedge clk) begin
        if (rstn && w_push && (occ_q == OCC_W'(e))) begin
          entry_q[e] <= w_ret_addr;
        end
      end
    end
  endgenerate

  assign cnt_val          = pc_q;
  assign max_size_reached = max_q;
  assign stack_full       = w_full;
  assign stack_empty      = w_empty;
  assign stack_err        = err_q;

endmodule
`default_nettype wire
